// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and memory handshake signals around the unified memory port arbiter.
// The slave view is the arbiter itself; the master view is the requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  ls_req_i;
    logic                  ls_we_i;
    logic [1:0]            ls_size_i;
    logic [ADDR_WIDTH-1:0] ls_addr_i;
    logic [DATA_WIDTH-1:0] ls_wdata_i;
    logic                  ls_gnt_o;
    logic                  ls_rvalid_o;
    logic [DATA_WIDTH-1:0] ls_rdata_o;
    logic                  ls_err_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_size_i, ls_addr_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight,
// with byte-enable/lane formation and local rejection of misaligned LSU accesses.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_FETCH_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic                busy_o
);
    localparam int SW = $clog2(MAX_FETCH_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_FETCH_WAIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        ERR_RESP  = 2'd2
    } state_t;

    state_t          state_reg;
    logic            owner_reg;
    logic [SW-1:0]   starve_reg;

    logic                  active_idle;
    logic                  fetch_sel;
    logic                  lsu_sel;
    logic                  misaligned;
    logic                  mem_req;
    logic                  if_gnt;
    logic                  ls_gnt;
    logic                  mem_resp;
    logic                  ls_resp;
    logic                  err_state;
    logic [3:0]            lsu_be;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] lsu_wdata;

    always_comb begin
        active_idle = rst_n && (state_reg == IDLE);
        // Fetch only overtakes a competing LSU request once it has waited MAX_FETCH_WAIT grants
        fetch_sel   = bus.if_req_i && (!bus.ls_req_i || (starve_reg == STARVE_MAX));
        lsu_sel     = bus.ls_req_i && !fetch_sel;

        misaligned = 1'b0;
        lsu_be     = 4'b1111;
        case (bus.ls_size_i)
            2'b00: lsu_be = 4'b0001 << bus.ls_addr_i[1:0];
            2'b01: begin
                misaligned = bus.ls_addr_i[0];
                lsu_be     = 4'b0011 << {bus.ls_addr_i[1], 1'b0};
            end
            default: misaligned = |bus.ls_addr_i[1:0];
        endcase

        mem_req   = active_idle && (fetch_sel || (lsu_sel && !misaligned));
        if_gnt    = active_idle && fetch_sel && bus.mem_gnt_i;
        ls_gnt    = active_idle && lsu_sel && (misaligned || bus.mem_gnt_i);
        sel_addr  = fetch_sel ? bus.if_addr_i : bus.ls_addr_i;
        mem_resp  = rst_n && (state_reg == WAIT_RESP) && bus.mem_rvalid_i;
        ls_resp   = mem_resp && owner_reg;
        err_state = rst_n && (state_reg == ERR_RESP);
    end

    // Store data is right-aligned; replicate it so every candidate lane carries it
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lsu_wdata[gi*8 +: 8] =
            (bus.ls_size_i == 2'b00) ? bus.ls_wdata_i[7:0] :
            (bus.ls_size_i == 2'b01) ? bus.ls_wdata_i[(gi % 2)*8 +: 8] :
                                       bus.ls_wdata_i[gi*8 +: 8];
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_req && lsu_sel && bus.ls_we_i;
    assign bus.mem_be_o    = !mem_req ? 4'b0000 : (fetch_sel ? 4'b1111 : lsu_be);
    assign bus.mem_addr_o  = mem_req ? (sel_addr & ~ADDR_WIDTH'(3)) : '0;
    assign bus.mem_wdata_o = (mem_req && lsu_sel) ? lsu_wdata : '0;

    assign bus.if_gnt_o    = if_gnt;
    assign bus.if_rvalid_o = mem_resp && !owner_reg;
    assign bus.if_rdata_o  = (mem_resp && !owner_reg) ? bus.mem_rdata_i : '0;

    assign bus.ls_gnt_o    = ls_gnt;
    assign bus.ls_rvalid_o = ls_resp || err_state;
    assign bus.ls_err_o    = err_state;
    assign bus.ls_rdata_o  = ls_resp ? bus.mem_rdata_i : '0;

    assign busy_o = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            starve_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (if_gnt) begin
                        owner_reg <= 1'b0;
                        state_reg <= WAIT_RESP;
                    end else if (ls_gnt) begin
                        owner_reg <= 1'b1;
                        state_reg <= misaligned ? ERR_RESP : WAIT_RESP;
                    end
                    if (!bus.if_req_i || if_gnt) begin
                        starve_reg <= '0;
                    end else if (ls_gnt && (starve_reg != STARVE_MAX)) begin
                        starve_reg <= starve_reg + 1'b1;
                    end
                end
                WAIT_RESP: begin
                    if (bus.mem_rvalid_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case sequences,
// and randomized traffic checked against a queue-based model of owed responses.
module tb_mem_port_arbiter;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MAX_FETCH_WAIT(MAXW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy_o(busy)
    );

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        ls_gnt;
        logic        ls_rvalid;
        logic        ls_err;
        logic [31:0] ls_rdata;
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        busy;
    } outs_t;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [1:0]  ls_size;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        bit lsu;
        bit err;
    } owed_t;

    int    vectors = 0;
    int    miscompares = 0;
    outs_t last_act;
    outs_t exp_cur;

    // Model: responses owed to requesters, plus how many LSU grants fetch has sat through
    owed_t owed[$];
    int    starve_m;
    bit    push_v, pop_v, rst_seen;
    owed_t push_e;
    int    starve_nx;

    function automatic outs_t sample();
        outs_t s;
        s.if_gnt    = bus.if_gnt_o;
        s.if_rvalid = bus.if_rvalid_o;
        s.if_rdata  = bus.if_rdata_o;
        s.ls_gnt    = bus.ls_gnt_o;
        s.ls_rvalid = bus.ls_rvalid_o;
        s.ls_err    = bus.ls_err_o;
        s.ls_rdata  = bus.ls_rdata_o;
        s.mem_req   = bus.mem_req_o;
        s.mem_we    = bus.mem_we_o;
        s.mem_be    = bus.mem_be_o;
        s.mem_addr  = bus.mem_addr_o;
        s.mem_wdata = bus.mem_wdata_o;
        s.busy      = busy;
        return s;
    endfunction

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        if (!exp.mem_we) begin
            act.mem_wdata = '0;
            exp.mem_wdata = '0;
        end
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: outputs got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_eval();
        bit fw, lw;
        int n, be_i;
        logic [31:0] a;
        exp_cur   = '0;
        push_v    = 1'b0;
        pop_v     = 1'b0;
        push_e    = '{1'b0, 1'b0};
        starve_nx = starve_m;
        rst_seen  = (rst_n !== 1'b1);
        if (rst_seen) return;
        if (owed.size() == 0) begin
            fw = bus.if_req_i && (!bus.ls_req_i || starve_m == MAXW);
            lw = bus.ls_req_i && !fw;
            if (fw) begin
                exp_cur.mem_req  = 1'b1;
                exp_cur.mem_be   = 4'hF;
                exp_cur.mem_addr = bus.if_addr_i & 32'hFFFF_FFFC;
                if (bus.mem_gnt_i) begin
                    exp_cur.if_gnt = 1'b1;
                    push_v = 1'b1;
                    push_e = '{1'b0, 1'b0};
                end
            end
            if (lw) begin
                n = (bus.ls_size_i == 2'd0) ? 1 : (bus.ls_size_i == 2'd1) ? 2 : 4;
                a = bus.ls_addr_i;
                if ((a % n) != 0) begin
                    exp_cur.ls_gnt = 1'b1;
                    push_v = 1'b1;
                    push_e = '{1'b1, 1'b1};
                end else begin
                    be_i = ((1 << n) - 1) << (a % 4);
                    exp_cur.mem_req  = 1'b1;
                    exp_cur.mem_we   = bus.ls_we_i;
                    exp_cur.mem_be   = be_i[3:0];
                    exp_cur.mem_addr = a - (a % 4);
                    for (int k = 0; k < 4; k++)
                        exp_cur.mem_wdata[8*k +: 8] = bus.ls_wdata_i[8*(k % n) +: 8];
                    if (bus.mem_gnt_i) begin
                        exp_cur.ls_gnt = 1'b1;
                        push_v = 1'b1;
                        push_e = '{1'b1, 1'b0};
                    end
                end
            end
            if (!bus.if_req_i || exp_cur.if_gnt) starve_nx = 0;
            else if (exp_cur.ls_gnt && starve_m < MAXW) starve_nx = starve_m + 1;
        end else begin
            exp_cur.busy = 1'b1;
            if (owed[0].err) begin
                exp_cur.ls_rvalid = 1'b1;
                exp_cur.ls_err    = 1'b1;
                pop_v = 1'b1;
            end else if (bus.mem_rvalid_i) begin
                if (owed[0].lsu) begin
                    exp_cur.ls_rvalid = 1'b1;
                    exp_cur.ls_rdata  = bus.mem_rdata_i;
                end else begin
                    exp_cur.if_rvalid = 1'b1;
                    exp_cur.if_rdata  = bus.mem_rdata_i;
                end
                pop_v = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        if (rst_seen) begin
            owed.delete();
            starve_m = 0;
        end else begin
            if (pop_v) void'(owed.pop_front());
            if (push_v) owed.push_back(push_e);
            starve_m = starve_nx;
        end
    endtask

    task automatic cycle(input string name);
        #4;
        model_eval();
        last_act = sample();
        check_outs(name, last_act, exp_cur);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive_quiet();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.ls_req_i     = 1'b0;
        bus.ls_we_i      = 1'b0;
        bus.ls_size_i    = 2'd0;
        bus.ls_addr_i    = '0;
        bus.ls_wdata_i   = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    vec_t  tbl[10];
    outs_t e;
    string order;

    initial begin
        rst_n = 1'b0;
        starve_m = 0;
        drive_quiet();
        tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b1, 1'b0, 4'hF, 32'h100, 32'h0};
        tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 32'h203, 32'hAB,       1'b1, 1'b1, 4'h8, 32'h200, 32'hABABABAB};
        tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 2'd1, 32'h006, 32'h1234,     1'b1, 1'b1, 4'hC, 32'h004, 32'h12341234};
        tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b0, 2'd0, 32'h201, 32'h0,        1'b1, 1'b0, 4'h2, 32'h200, 32'h0};
        tbl[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 2'd2, 32'h310, 32'h11223344, 1'b1, 1'b1, 4'hF, 32'h310, 32'h11223344};
        tbl[5] = '{1'b1, 32'h100, 1'b1, 1'b0, 2'd2, 32'h400, 32'h0,        1'b1, 1'b0, 4'hF, 32'h400, 32'h0};
        tbl[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 2'd1, 32'h102, 32'h0,        1'b1, 1'b0, 4'hC, 32'h100, 32'h0};
        tbl[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 2'd3, 32'h008, 32'hCAFEF00D, 1'b1, 1'b1, 4'hF, 32'h008, 32'hCAFEF00D};
        tbl[8] = '{1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 32'h0,   32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   32'h0};
        tbl[9] = '{1'b0, 32'h0,   1'b1, 1'b1, 2'd1, 32'h000, 32'hFFFFBEEF, 1'b1, 1'b1, 4'h3, 32'h000, 32'hBEEFBEEF};

        @(posedge clk); #1;
        cycle("reset");
        check_val("reset_busy", 32'(last_act.busy), 32'd0);
        rst_n = 1'b1;
        cycle("idle");

        // Directed single-cycle vectors, memory never grants so the arbiter stays idle
        for (int i = 0; i < 10; i++) begin
            bus.if_req_i   = tbl[i].if_req;
            bus.if_addr_i  = tbl[i].if_addr;
            bus.ls_req_i   = tbl[i].ls_req;
            bus.ls_we_i    = tbl[i].ls_we;
            bus.ls_size_i  = tbl[i].ls_size;
            bus.ls_addr_i  = tbl[i].ls_addr;
            bus.ls_wdata_i = tbl[i].ls_wdata;
            cycle("table_model");
            e = '0;
            e.mem_req   = tbl[i].e_req;
            e.mem_we    = tbl[i].e_we;
            e.mem_be    = tbl[i].e_be;
            e.mem_addr  = tbl[i].e_addr;
            e.mem_wdata = tbl[i].e_wdata;
            check_outs($sformatf("table_row%0d", i), last_act, e);
        end
        drive_quiet();
        cycle("idle");

        // Fetch with one-cycle memory
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100; bus.mem_gnt_i = 1'b1;
        cycle("fetch_req");
        check_val("fetch_gnt", 32'(last_act.if_gnt), 32'd1);
        drive_quiet();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
        cycle("fetch_resp");
        check_val("fetch_rvalid", 32'(last_act.if_rvalid), 32'd1);
        check_val("fetch_rdata", last_act.if_rdata, 32'hDEADBEEF);
        check_val("fetch_ls_rvalid", 32'(last_act.ls_rvalid), 32'd0);
        check_val("fetch_busy", 32'(last_act.busy), 32'd1);
        drive_quiet();
        cycle("fetch_done");
        check_val("fetch_busy_end", 32'(last_act.busy), 32'd0);

        // Both requesting continuously: fetch gets every fifth grant
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
        bus.ls_req_i = 1'b1; bus.ls_size_i = 2'd2; bus.ls_addr_i = 32'h400;
        bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5555AAAA;
        order = "";
        for (int c = 0; c < 20; c++) begin
            cycle("starve");
            if (last_act.ls_gnt) order = {order, "L"};
            if (last_act.if_gnt) order = {order, "F"};
        end
        vectors++;
        if (order != "LLLLFLLLLF") begin
            miscompares++;
            $display("FAIL grant_order: got %s expected LLLLFLLLLF", order);
        end
        drive_quiet();
        cycle("idle");

        // Misaligned word load answers locally with an error
        bus.ls_req_i = 1'b1; bus.ls_size_i = 2'd2; bus.ls_addr_i = 32'h102;
        cycle("misal_req");
        check_val("misal_mem_req", 32'(last_act.mem_req), 32'd0);
        check_val("misal_gnt", 32'(last_act.ls_gnt), 32'd1);
        drive_quiet();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h77777777;
        cycle("misal_resp");
        check_val("misal_rvalid", 32'(last_act.ls_rvalid), 32'd1);
        check_val("misal_err", 32'(last_act.ls_err), 32'd1);
        check_val("misal_rdata", last_act.ls_rdata, 32'd0);
        drive_quiet();
        cycle("idle");

        // Memory stalls the grant for three cycles
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
        for (int c = 0; c < 3; c++) begin
            cycle("stall");
            check_val("stall_mem_req", 32'(last_act.mem_req), 32'd1);
            check_val("stall_if_gnt", 32'(last_act.if_gnt), 32'd0);
        end
        bus.mem_gnt_i = 1'b1;
        cycle("stall_gnt");
        check_val("stall_gnt_after", 32'(last_act.if_gnt), 32'd1);
        drive_quiet();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h01020304;
        cycle("stall_resp");
        drive_quiet();

        // Reset while waiting for a response drops that response
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100; bus.mem_gnt_i = 1'b1;
        cycle("rst_mid_req");
        drive_quiet();
        rst_n = 1'b0;
        cycle("rst_mid_low");
        rst_n = 1'b1;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
        cycle("rst_stale");
        check_val("rst_stale_if", 32'(last_act.if_rvalid), 32'd0);
        check_val("rst_stale_ls", 32'(last_act.ls_rvalid), 32'd0);
        drive_quiet();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h104; bus.mem_gnt_i = 1'b1;
        cycle("rst_after_req");
        drive_quiet();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE0001;
        cycle("rst_after_resp");
        check_val("rst_after_rdata", last_act.if_rdata, 32'hCAFE0001);
        drive_quiet();
        cycle("idle");

        // Randomized traffic; payloads held until granted
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            bus.mem_gnt_i    = 1'($urandom_range(0, 1));
            bus.mem_rvalid_i = 1'($urandom_range(0, 1));
            bus.mem_rdata_i  = $urandom;
            cycle("random");
            if (!bus.if_req_i || exp_cur.if_gnt) begin
                bus.if_req_i  = ($urandom_range(0, 2) != 0);
                bus.if_addr_i = $urandom & 32'h0000_0FFC;
            end
            if (!bus.ls_req_i || exp_cur.ls_gnt) begin
                bus.ls_req_i   = ($urandom_range(0, 2) != 0);
                bus.ls_we_i    = 1'($urandom_range(0, 1));
                bus.ls_size_i  = 2'($urandom_range(0, 3));
                bus.ls_addr_i  = $urandom & 32'h0000_03FF;
                bus.ls_wdata_i = $urandom;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single unified memory port between instruction fetch and the load/store unit (LSU). Sits between the fetch stage / LSU and the memory interface. Allows one outstanding transaction at a time and routes each response back to its owner. Forms byte enables from the decoded access size, and rejects misaligned LSU accesses locally.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (fixed 32 for byte-enable logic)
- MAX_FETCH_WAIT, 4, consecutive LSU grants allowed while fetch waits before fetch is forced first (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request
- if_addr_i  in  ADDR_WIDTH  fetch address (word aligned)
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_WIDTH  fetch response data
- ls_req_i  in  1  LSU request
- ls_we_i  in  1  1 = store
- ls_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ls_addr_i  in  ADDR_WIDTH  LSU byte address
- ls_wdata_i  in  DATA_WIDTH  store data, right-aligned
- ls_gnt_o  out  1  LSU request accepted
- ls_rvalid_o  out  1  LSU response valid (loads and stores)
- ls_rdata_o  out  DATA_WIDTH  raw memory word (extension done by LSU)
- ls_err_o  out  1  misaligned access, qualified by ls_rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_WIDTH  word address ({addr[ADDR_WIDTH-1:2],2'b00})
- mem_wdata_o  out  DATA_WIDTH  store data shifted to byte lane
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response (also issued for writes)
- mem_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, WAIT_RESP, ERR_RESP. Registers: state, owner (0 fetch / 1 LSU), starve counter ($clog2(MAX_FETCH_WAIT+1) bits).
- IDLE selection: LSU wins if both request, unless starve == MAX_FETCH_WAIT, then fetch wins. Single requester always wins.
- IDLE, selected aligned request: mem_req_o=1, mem_* driven from selected source; mem_gnt_i forwarded to the selected requester's gnt only. On mem_gnt_i: latch owner, go WAIT_RESP.
- Starve: +1 (saturating) on each LSU grant while if_req_i=1; cleared on fetch grant or when if_req_i=0 in IDLE.
- Misaligned LSU (half with addr[0]=1; word with addr[1:0]≠0) selected: mem_req_o=0, ls_gnt_o=1 immediately, go ERR_RESP. Counts as LSU grant for starve.
- WAIT_RESP: mem_req_o=0, gnts 0. On mem_rvalid_i: owner's rvalid=1, rdata=mem_rdata_i; go IDLE.
- ERR_RESP: ls_rvalid_o=1, ls_err_o=1, ls_rdata_o=0 for one cycle; go IDLE.
- mem_rvalid_i in IDLE or ERR_RESP is ignored (stale after reset).
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; fetch 4'b1111, we=0.
- Write data: byte replicated on all four lanes, half on both halves, word unchanged.

## Timing
- Reset: state IDLE, owner 0, starve 0; all gnt/rvalid/err/mem_req/mem_we outputs 0, mem_be 0, data/address outputs 0.
- Request/grant/response paths are combinational pass-through in the owning state; no added latency.
- Back-to-back with 1-cycle memory: grant cycle N, rvalid N+1, next grant N+2 (2 cycles/transaction).
- Requesters hold req and payload stable until gnt; arbiter may switch selection only while mem_gnt_i=0 in IDLE (memory must tolerate request withdrawal).
- Reset asserted mid-transaction: immediate return to IDLE; pending response lost, later rvalid dropped.

## Test plan
- Fetch only, addr 0x100, memory gnt same cycle, rvalid next with 0xDEADBEEF -> if_rvalid_o=1, if_rdata_o=0xDEADBEEF, ls_rvalid_o=0, busy_o 1 for one cycle.
- Store byte 0xAB at 0x203 -> mem_be_o=4'b1000, mem_addr_o=0x200, mem_wdata_o=0xABABABAB, mem_we_o=1.
- Continuous ls_req_i and if_req_i, MAX_FETCH_WAIT=4 -> grant order LSU×4, fetch, LSU×4, fetch.
- Load word at 0x102 -> no mem_req_o; ls_gnt_o same cycle, next cycle ls_rvalid_o=1, ls_err_o=1, ls_rdata_o=0.
- rst_n low while in WAIT_RESP, release, then mem_rvalid_i=1 -> no rvalid to either requester; next fetch completes normally.
- Memory withholds gnt 3 cycles -> mem_req_o held, if_gnt_o=0 until mem_gnt_i; half store at 0x006 gives mem_be_o=4'b1100.
